// File: rtl/calc_datapath.sv
// Register-file and ALU datapath for the calculator, driven cycle by cycle by the control FSM's control word.
// Optional flag logic (carry, overflow, zero) is built only when CALC_DP_FLAGS_EN is defined.
module calc_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [1:0]       s1_mux,
   input  logic [1:0]       wa,
   input  logic             we,
   input  logic [1:0]       raa,
   input  logic             rea,
   input  logic [1:0]       rab,
   input  logic             reb,
   input  logic [1:0]       c,
   input  logic             s2_mux,
   input  logic             Done,
   output logic [WIDTH-1:0] Out,
   output logic             out_valid,
   output logic             done_q,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   logic [WIDTH-1:0] rf_q [4];
   logic [WIDTH-1:0] rf_d [4];
   logic [WIDTH-1:0] port_a_s;
   logic [WIDTH-1:0] port_b_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] wd_s;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic             done_dly_q;
   logic             done_dly_d;

   // Read ports: a disabled port reads as zero.
   always_comb begin
      port_a_s = {WIDTH{1'b0}};
      port_b_s = {WIDTH{1'b0}};
      if (rea) port_a_s = rf_q[raa];
      else     port_a_s = {WIDTH{1'b0}};
      if (reb) port_b_s = rf_q[rab];
      else     port_b_s = {WIDTH{1'b0}};
   end

   // ALU result, truncated to WIDTH; subtraction is A + ~B + 1.
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      case (c)
         2'b11:   alu_res_s = port_a_s + port_b_s;
         2'b10:   alu_res_s = port_a_s + ~port_b_s + {{(WIDTH-1){1'b0}}, 1'b1};
         2'b01:   alu_res_s = port_a_s & port_b_s;
         2'b00:   alu_res_s = port_a_s ^ port_b_s;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Write-data select.
   always_comb begin
      wd_s = {WIDTH{1'b0}};
      case (s1_mux)
         2'b11:   wd_s = In1;
         2'b10:   wd_s = In2;
         2'b00:   wd_s = alu_res_s;
         2'b01:   wd_s = {WIDTH{1'b0}};
         default: wd_s = {WIDTH{1'b0}};
      endcase
   end

   // Next state for register file, output register and done delay.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (we && (wa == 2'(i))) rf_d[i] = wd_s;
         else                     rf_d[i] = rf_q[i];
      end
      if (s2_mux) begin
         out_d       = alu_res_s;
         out_valid_d = 1'b1;
      end else begin
         out_d       = out_q;
         out_valid_d = out_valid_q;
      end
      done_dly_d = Done;
   end

   // Core state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rf_q[i] <= {WIDTH{1'b0}};
         out_q       <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         done_dly_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_dly_q  <= done_dly_d;
      end
   end

   assign Out       = out_q;
   assign out_valid = out_valid_q;
   assign done_q    = done_dly_q;

`ifdef CALC_DP_FLAGS_EN
   logic b_eff_msb_s;
   logic alu_c_s;
   logic alu_v_s;
   logic flag_c_q, flag_c_d;
   logic flag_v_q, flag_v_d;
   logic flag_z_q, flag_z_d;

   // Carry and overflow come from the MSB column alone: carry-out is the majority of a, b and the recovered carry-in.
   always_comb begin
      alu_c_s     = 1'b0;
      alu_v_s     = 1'b0;
      b_eff_msb_s = (c == 2'b10) ? ~port_b_s[WIDTH-1] : port_b_s[WIDTH-1];
      if ((c == 2'b11) || (c == 2'b10)) begin
         alu_c_s = (port_a_s[WIDTH-1] & b_eff_msb_s) |
                   ((port_a_s[WIDTH-1] | b_eff_msb_s) & ~alu_res_s[WIDTH-1]);
         alu_v_s = (port_a_s[WIDTH-1] == b_eff_msb_s) && (alu_res_s[WIDTH-1] != port_a_s[WIDTH-1]);
      end else begin
         alu_c_s = 1'b0;
         alu_v_s = 1'b0;
      end
   end

   // Flags latch only on ALU write-back; zero flag tracks the next Out value.
   always_comb begin
      if (we && (s1_mux == 2'b00)) begin
         flag_c_d = alu_c_s;
         flag_v_d = alu_v_s;
      end else begin
         flag_c_d = flag_c_q;
         flag_v_d = flag_v_q;
      end
      flag_z_d = (out_d == {WIDTH{1'b0}});
   end

   // Flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_z_q <= 1'b1;
      end else begin
         flag_c_q <= flag_c_d;
         flag_v_q <= flag_v_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign flag_c = flag_c_q;
   assign flag_v = flag_v_q;
   assign flag_z = flag_z_q;
`else
   assign flag_c = 1'b0;
   assign flag_v = 1'b0;
   assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed FSM sequences plus randomized control words against an integer model.
module tb_calc_datapath;

`ifdef CALC_DP_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic       clk, reset;
   logic [7:0] In1, In2;
   logic [1:0] s1_mux, wa, raa, rab, c;
   logic       we, rea, reb, s2_mux, Done;
   logic [7:0] Out;
   logic       out_valid, done_q, flag_z, flag_c, flag_v;

   int checks   = 0;
   int failures = 0;

   int m_r [4];
   int m_out;
   bit m_valid, m_done, m_fc, m_fv;

   calc_datapath #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .In1(In1), .In2(In2), .s1_mux(s1_mux), .wa(wa), .we(we),
      .raa(raa), .rea(rea), .rab(rab), .reb(reb), .c(c), .s2_mux(s2_mux), .Done(Done),
      .Out(Out), .out_valid(out_valid), .done_q(done_q), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference ALU on plain integers: unsigned result mod 256, signed range check for overflow.
   function automatic void model_alu(input int a, input int b, input logic [1:0] op,
                                     output int r, output bit cy, output bit ov);
      int sa, sb, full, sfull;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      cy = 1'b0; ov = 1'b0; sfull = 0;
      case (op)
         2'b11:   begin full = a + b; sfull = sa + sb; cy = (full > 255); end
         2'b10:   begin full = a - b; sfull = sa - sb; cy = (a >= b); end
         2'b01:   full = a & b;
         default: full = a ^ b;
      endcase
      if (op[1]) ov = (sfull > 127) || (sfull < -128);
      r = full & 255;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_out = 0; m_valid = 0; m_done = 0; m_fc = 0; m_fv = 0;
   endtask

   // Drive one control word, advance one clock, and update the model.
   task automatic cyc(input logic [1:0] s1, input logic [1:0] w_a, input logic w_e,
                      input logic [1:0] ra, input logic r_ea, input logic [1:0] rb, input logic r_eb,
                      input logic [1:0] op, input logic s2, input logic dn);
      int a, b, r, wd;
      bit cy, ov;
      s1_mux = s1; wa = w_a; we = w_e; raa = ra; rea = r_ea; rab = rb; reb = r_eb;
      c = op; s2_mux = s2; Done = dn;
      a = r_ea ? m_r[ra] : 0;
      b = r_eb ? m_r[rb] : 0;
      model_alu(a, b, op, r, cy, ov);
      case (s1)
         2'b11:   wd = int'(In1);
         2'b10:   wd = int'(In2);
         2'b00:   wd = r;
         default: wd = 0;
      endcase
      @(posedge clk);
      if (w_e) m_r[w_a] = wd;
      if (w_e && s1 == 2'b00) begin m_fc = cy; m_fv = ov; end
      if (s2) begin m_out = r; m_valid = 1'b1; end
      m_done = dn;
      #1;
   endtask

   // FSM sequence: load1 -> load2 -> wait -> op (R3 <= R1 op R2) -> loadout (Out <= R3).
   task automatic run_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      In1 = a; In2 = b;
      cyc(2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      cyc(2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      cyc(2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      cyc(2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, op,    1'b0, 1'b0);
      cyc(2'b01, 2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      In1 = 8'h00; In2 = 8'h00; s1_mux = 2'b00; wa = 2'b00; we = 1'b0; raa = 2'b00; rea = 1'b0;
      rab = 2'b00; reb = 1'b0; c = 2'b00; s2_mux = 1'b0; Done = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (Out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", Out); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (done_q !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_q); end
      checks++; if ({flag_z, flag_c, flag_v} !== {FLAGS, 1'b0, 1'b0})
         begin failures++; $display("FAIL reset_flags got zcv=%b%b%b exp=%b00", flag_z, flag_c, flag_v, FLAGS); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      run_calc(2'b11, 8'd200, 8'd100);
      checks++; if (Out !== 8'h2C) begin failures++; $display("FAIL add_out got=%h exp=2c", Out); end
      checks++; if (done_q !== 1'b1) begin failures++; $display("FAIL add_done_q got=%b exp=1", done_q); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
      checks++; if ({flag_c, flag_v} !== {FLAGS, 1'b0})
         begin failures++; $display("FAIL add_flags got cv=%b%b exp=%b0", flag_c, flag_v, FLAGS); end
      // Read R3 back through the ALU (A + 0).
      cyc(2'b01, 2'b00, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
      checks++; if (Out !== 8'h2C) begin failures++; $display("FAIL add_r3 got=%h exp=2c", Out); end
      checks++; if (done_q !== 1'b0) begin failures++; $display("FAIL add_done_fall got=%b exp=0", done_q); end
   endtask

   task automatic test_sub();
      run_calc(2'b10, 8'd5, 8'd7);
      checks++; if (Out !== 8'hFE) begin failures++; $display("FAIL sub_out got=%h exp=fe", Out); end
      checks++; if ({flag_c, flag_v} !== 2'b00)
         begin failures++; $display("FAIL sub_flags got cv=%b%b exp=00", flag_c, flag_v); end
      run_calc(2'b10, 8'h80, 8'h01);
      checks++; if (Out !== 8'h7F) begin failures++; $display("FAIL sub_ovf_out got=%h exp=7f", Out); end
      checks++; if ({flag_c, flag_v} !== {FLAGS, FLAGS})
         begin failures++; $display("FAIL sub_ovf_flags got cv=%b%b exp=%b%b", flag_c, flag_v, FLAGS, FLAGS); end
   endtask

   task automatic test_logic();
      run_calc(2'b01, 8'hF0, 8'h3C);
      checks++; if (Out !== 8'h30) begin failures++; $display("FAIL and_out got=%h exp=30", Out); end
      run_calc(2'b00, 8'hAA, 8'hAA);
      checks++; if (Out !== 8'h00) begin failures++; $display("FAIL xor_out got=%h exp=00", Out); end
      checks++; if ({flag_z, flag_c, flag_v} !== {FLAGS, 1'b0, 1'b0})
         begin failures++; $display("FAIL xor_flags got zcv=%b%b%b exp=%b00", flag_z, flag_c, flag_v, FLAGS); end
   endtask

   task automatic test_same_cycle_rw();
      In1 = 8'h11;
      cyc(2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      In1 = 8'h22;
      cyc(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
      checks++; if (Out !== 8'h11) begin failures++; $display("FAIL rw_old got=%h exp=11", Out); end
      cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
      checks++; if (Out !== 8'h22) begin failures++; $display("FAIL rw_new got=%h exp=22", Out); end
   endtask

   task automatic test_read_disable();
      cyc(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0);
      checks++; if (Out !== 8'h00) begin failures++; $display("FAIL rd_dis_out got=%h exp=00", Out); end
      checks++; if (flag_z !== FLAGS) begin failures++; $display("FAIL rd_dis_z got=%b exp=%b", flag_z, FLAGS); end
   endtask

   task automatic test_reset_mid_op();
      run_calc(2'b11, 8'h12, 8'h34);
      In1 = 8'h55; In2 = 8'h66;
      cyc(2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      cyc(2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      // Op state control word, then asynchronous reset before the edge.
      s1_mux = 2'b00; wa = 2'b11; we = 1'b1; raa = 2'b01; rea = 1'b1; rab = 2'b10; reb = 1'b1;
      c = 2'b11; s2_mux = 1'b1; Done = 1'b1;
      #2 reset = 1'b1;
      #1;
      model_clear();
      checks++; if (Out !== 8'h00) begin failures++; $display("FAIL rst_mid_out got=%h exp=00", Out); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
      checks++; if (flag_z !== FLAGS) begin failures++; $display("FAIL rst_mid_z got=%b exp=%b", flag_z, FLAGS); end
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(2'b01, 2'b00, 1'b0, 2'(i), 1'b1, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
         checks++; if (Out !== 8'h00) begin failures++; $display("FAIL rst_mid_r%0d got=%h exp=00", i, Out); end
      end
      run_calc(2'b11, 8'h21, 8'h13);
      checks++; if (Out !== 8'h34) begin failures++; $display("FAIL rst_mid_fresh got=%h exp=34", Out); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         In1 = 8'($urandom); In2 = 8'($urandom);
         cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
         checks++;
         if ({Out, out_valid, done_q} !== {m_out[7:0], m_valid, m_done}) begin
            failures++;
            $display("FAIL rand_core n=%0d got out=%h v=%b d=%b exp out=%h v=%b d=%b",
                     n, Out, out_valid, done_q, m_out[7:0], m_valid, m_done);
         end
         checks++;
         if ({flag_z, flag_c, flag_v} !== {FLAGS & (m_out == 0), FLAGS & m_fc, FLAGS & m_fv}) begin
            failures++;
            $display("FAIL rand_flags n=%0d got zcv=%b%b%b exp=%b%b%b", n, flag_z, flag_c, flag_v,
                     FLAGS & (m_out == 0), FLAGS & m_fc, FLAGS & m_fv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_same_cycle_rw();
      test_read_disable();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
